// File: rtl/jtag_bus_master_if.sv
// Purpose: host byte stream, response byte stream and memory bus of the JTAG bus master.
// Latency: wires only, no storage.
// Backpressure: io_tx_ready stalls responses; io_mem_ack completes a bus request.
interface jtag_bus_master_if;
  logic        io_rx_valid;
  logic [7:0]  io_rx_data;
  logic        io_tx_valid;
  logic [7:0]  io_tx_data;
  logic        io_tx_ready;
  logic        io_mem_req;
  logic        io_mem_we;
  logic [31:0] io_mem_addr;
  logic [31:0] io_mem_wdata;
  logic        io_mem_ack;
  logic [31:0] io_mem_rdata;
  logic        io_busy;
  logic        io_err;

  // Controller side.
  modport master (
    input  io_rx_valid, io_rx_data, io_tx_ready, io_mem_ack, io_mem_rdata,
    output io_tx_valid, io_tx_data, io_mem_req, io_mem_we, io_mem_addr,
    output io_mem_wdata, io_busy, io_err
  );

  // Host and bus side.
  modport slave (
    output io_rx_valid, io_rx_data, io_tx_ready, io_mem_ack, io_mem_rdata,
    input  io_tx_valid, io_tx_data, io_mem_req, io_mem_we, io_mem_addr,
    input  io_mem_wdata, io_busy, io_err
  );
endinterface

// File: rtl/jtag_bus_master.sv
// Purpose: assemble JTAG host bytes into bus read/write commands, stream read data back.
// Latency: last command byte in cycle N -> io_mem_req in cycle N+1; read data on tx the cycle after ack.
// Backpressure: none on rx (bytes arriving in REQ/RESP are dropped and flag io_err); tx holds while !io_tx_ready.
module jtag_bus_master #(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  jtag_bus_master_if.master  bus
);

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_CLRERR = 8'h03;

  // Counter only needs to reach TIMEOUT-1; expiry is detected on that value.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    REQ   = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic            is_write;
  logic [1:0]      byte_cnt;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic [TW-1:0]   tmo_cnt;
  logic            err;
  logic            err_set;
  logic            err_clr;
  logic [7:0]      tx_byte;

  // State register; async reset returns to IDLE so req/tx_valid drop at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode plus error set/clear events.
  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.io_rx_valid) begin
          case (bus.io_rx_data)
            OP_WRITE, OP_READ: state_nxt = ADDR;
            OP_CLRERR:         err_clr   = 1'b1;
            OP_NOP:            ;
            default:           err_set   = 1'b1;
          endcase
        end
      end
      ADDR: begin
        if (bus.io_rx_valid && byte_cnt == 2'd3)
          state_nxt = is_write ? WDATA : REQ;
      end
      WDATA: begin
        if (bus.io_rx_valid && byte_cnt == 2'd3)
          state_nxt = REQ;
      end
      REQ: begin
        if (bus.io_rx_valid) err_set = 1'b1;
        // Ack takes priority over a coincident timeout expiry.
        if (bus.io_mem_ack) begin
          state_nxt = is_write ? IDLE : RESP;
        end else if ((TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
        end
      end
      RESP: begin
        if (bus.io_rx_valid) err_set = 1'b1;
        if (bus.io_tx_ready && byte_cnt == 2'd3)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command/data capture, byte counting and the REQ wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_write <= 1'b0;
      byte_cnt <= 2'd0;
      addr     <= 32'd0;
      wdata    <= 32'd0;
      rdata    <= 32'd0;
      tmo_cnt  <= '0;
    end else begin
      tmo_cnt <= (state == REQ && !bus.io_mem_ack) ? tmo_cnt + 1'b1 : '0;
      case (state)
        IDLE: begin
          if (bus.io_rx_valid &&
              (bus.io_rx_data == OP_WRITE || bus.io_rx_data == OP_READ)) begin
            is_write <= (bus.io_rx_data == OP_WRITE);
            byte_cnt <= 2'd0;
          end
        end
        ADDR: begin
          if (bus.io_rx_valid) begin
            addr     <= {addr[23:0], bus.io_rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        WDATA: begin
          if (bus.io_rx_valid) begin
            wdata    <= {wdata[23:0], bus.io_rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        REQ: begin
          if (bus.io_mem_ack) begin
            if (!is_write) rdata <= bus.io_mem_rdata;
            byte_cnt <= 2'd0;
          end
        end
        RESP: begin
          if (bus.io_tx_ready) byte_cnt <= byte_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Sticky error flag; a new error event beats a coincident CLRERR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

  // Response byte select, MSB first.
  always_comb begin
    tx_byte = rdata[31:24];
    case (byte_cnt)
      2'd0: tx_byte = rdata[31:24];
      2'd1: tx_byte = rdata[23:16];
      2'd2: tx_byte = rdata[15:8];
      2'd3: tx_byte = rdata[7:0];
      default: tx_byte = rdata[31:24];
    endcase
  end

  assign bus.io_mem_req   = (state == REQ);
  assign bus.io_mem_we    = (state == REQ) && is_write;
  assign bus.io_mem_addr  = addr;
  assign bus.io_mem_wdata = wdata;
  assign bus.io_tx_valid  = (state == RESP);
  assign bus.io_tx_data   = tx_byte;
  assign bus.io_busy      = (state != IDLE);
  assign bus.io_err       = err;

endmodule

// File: doc/jtag_bus_master.md
Name: jtag_bus_master

Overview:
- Byte-stream command controller between the virtual-JTAG interface and an on-chip memory/register bus.
- Assembles host bytes into read/write commands and drives one bus transaction at a time with a req/ack handshake.
- Returns read data to the JTAG interface as a byte stream.
- Lets the host PC peek and poke memory-mapped state of the core over JTAG.

Parameters:
- TIMEOUT, 255: max cycles waiting for io_mem_ack; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- io_rx_valid  in  1  one-cycle strobe: a host byte is present on io_rx_data (already synchronised to clk)
- io_rx_data  in  8  host byte
- io_tx_valid  out  1  response byte available
- io_tx_data  out  8  response byte
- io_tx_ready  in  1  consumer accepts io_tx_data this cycle
- io_mem_req  out  1  bus request
- io_mem_we  out  1  1 = write, 0 = read
- io_mem_addr  out  32  bus address
- io_mem_wdata  out  32  write data
- io_mem_ack  in  1  bus completion; io_mem_rdata is valid in the same cycle
- io_mem_rdata  in  32  read data
- io_busy  out  1  high in any state other than IDLE
- io_err  out  1  sticky error flag

Behaviour:
- Reset: all outputs 0; state IDLE; internal address, data and byte counters cleared.
- Command format: opcode byte, then 4 address bytes MSB first; WRITE is followed by 4 data bytes MSB first.
- Opcodes:
  - 0x01 WRITE
  - 0x02 READ
  - 0x03 CLRERR (clears io_err in the next cycle)
  - 0x00 NOP (ignored)
  - any other value: set io_err, stay in IDLE.
- States: IDLE, ADDR, WDATA, REQ, RESP.
- IDLE:
  - On io_rx_valid, decode the opcode.
  - WRITE or READ → ADDR, byte counter = 0.
- ADDR:
  - Each strobe shifts a byte into addr[31:0] from MSB down.
  - On the 4th byte: WRITE → WDATA; READ → REQ.
- WDATA: same shifting into wdata; 4th byte → REQ.
- Latency: the last command byte strobed in cycle N gives io_mem_req = 1 in cycle N+1.
- REQ:
  - io_mem_req held high; io_mem_we, io_mem_addr and io_mem_wdata held stable until the cycle io_mem_ack = 1.
  - Ack in the first REQ cycle is legal.
  - On ack, io_mem_req drops the next cycle.
  - After ack: WRITE → IDLE; READ → latch io_mem_rdata → RESP.
- Timeout (TIMEOUT > 0):
  - A cycle counter runs while in REQ.
  - On reaching TIMEOUT without ack: drop io_mem_req, set io_err, → IDLE, no response bytes sent.
  - An ack arriving in the same cycle as expiry wins; no error.
- RESP:
  - Present rdata bytes MSB first on io_tx_data, with io_tx_valid = 1.
  - Advance one byte on each cycle with io_tx_valid && io_tx_ready.
  - io_tx_data stays stable while io_tx_ready = 0.
  - After the 4th transfer: io_tx_valid = 0 in the next cycle, → IDLE.
- Overrun: io_rx_valid in REQ or RESP discards the byte and sets io_err; state is unaffected.
- io_err is sticky. It clears only on CLRERR or reset. If an error event and CLRERR coincide, the error event wins.
- Reset asserted mid-transaction: io_mem_req and io_tx_valid drop immediately (asynchronously); state → IDLE.
- io_mem_addr and io_mem_wdata hold their last values in IDLE and are don't-care to the bus when io_mem_req = 0.

Test Plan:
1. Write: rx bytes 01 00 00 10 00 DE AD BE EF; ack 3 cycles after req → one req with we=1, addr=0x00001000, wdata=0xDEADBEEF; io_busy falls after ack; io_err=0.
2. Read with backpressure: rx 02 00 00 00 04; ack with rdata=0x12345678; io_tx_ready toggled 1,0,0,1,1,1 → tx bytes 12,34,56,78 in order, each held stable while ready=0; io_tx_valid=0 afterwards.
3. Timeout: TIMEOUT=8; READ command, ack never asserted → req drops 8 cycles after rising; io_err=1; no tx bytes; then rx 03 → io_err=0.
4. Bad opcode and overrun: rx 0x55 → io_err=1, state IDLE. Separately, a byte strobed during REQ → discarded, io_err=1, transaction completes normally.
5. Reset mid-RESP: reset low after the 2nd tx byte → io_tx_valid=0 immediately; after release, io_busy=0 and a fresh WRITE completes correctly.
6. Same-cycle ack: ack in the first REQ cycle for back-to-back WRITEs → exactly one req pulse each, no timeout, no error.
